// File: rtl/fetch_pkg.sv
// Shared defaults and the {instr, pc} entry carried through the fetch buffer.
package fetch_pkg;

  localparam int          DEF_ADDR_WIDTH  = 32;
  localparam int          DEF_INSTR_WIDTH = 32;
  localparam logic [31:0] DEF_RESET_PC    = 32'h0000_0000;
  localparam int          DEF_PC_STEP     = 4;

  typedef struct packed {
    logic [DEF_INSTR_WIDTH-1:0] instr;
    logic [DEF_ADDR_WIDTH-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/flipflop.sv
// Enabled register, no internal reset; the owner drives the reset value through d.
// Latency 1 cycle; loads d on any enabled rising edge.
module flipflop #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (en) q <= d;
  end

endmodule

// File: rtl/fetch_stage.sv
// Sequential instruction fetch into a 2-entry {instr, pc} buffer; issue to out_valid is 2 cycles.
// Backpressure: issue stalls while buffered plus in-flight entries would exceed 2; redirect/reset flush.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int                    INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(DEF_RESET_PC),
  parameter int                    PC_STEP     = DEF_PC_STEP
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   redirect,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   imem_en,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0]  out_pc
);

  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic                  issue;
  logic                  fire;
  logic                  flush;
  logic                  infl;
  logic [ADDR_WIDTH-1:0] infl_pc;
  logic                  wr;
  logic [1:0]            count;
  logic [1:0]            slot;
  logic [2:0]            occupancy;
  fetch_entry_t          fifo_q [2];

  assign flush     = reset | redirect;
  assign fire      = out_valid & out_ready;
  // fire implies count >= 1, so this never underflows.
  assign occupancy = {1'b0, count} + {2'b00, infl} - {2'b00, fire};
  assign issue     = (occupancy < 3'd2) & ~flush;

  assign pc_next = reset    ? RESET_PC :
                   redirect ? redirect_pc :
                              pc + ADDR_WIDTH'(PC_STEP);

  flipflop #(.WIDTH(ADDR_WIDTH)) u_pc (
    .clk (clk),
    .en  (reset | redirect | issue),
    .d   (pc_next),
    .q   (pc)
  );

  assign imem_en   = issue;
  assign imem_addr = pc;

  // A response returning during a flush belongs to the old path and is dropped.
  assign wr   = infl & ~flush;
  assign slot = count - {1'b0, fire};

  always_ff @(posedge clk) begin
    if (reset) infl <= 1'b0;
    else       infl <= issue;
    if (issue) infl_pc <= pc;
  end

  always_ff @(posedge clk) begin
    if (flush) count <= 2'd0;
    else       count <= count + {1'b0, wr} - {1'b0, fire};
  end

  always_ff @(posedge clk) begin
    if (fire) fifo_q[0] <= fifo_q[1];
    if (wr)   fifo_q[slot[0]] <= '{instr: imem_rdata, pc: infl_pc};
  end

  assign out_valid = (count != 2'd0) & ~reset;
  assign out_instr = fifo_q[0].instr;
  assign out_pc    = fifo_q[0].pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an address-derived memory model and an expected-PC scoreboard.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  logic        w_redirect = 1'b0;
  logic [31:0] w_redirect_pc = 32'h0;
  logic        w_ready = 1'b1;
  logic        w_imem_en;
  logic [31:0] w_imem_addr;
  logic [31:0] w_imem_rdata;
  logic        w_out_valid;
  logic [31:0] w_out_instr;
  logic [31:0] w_out_pc;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q [$];
  logic        prev_stall = 1'b0;
  logic        prev_flush = 1'b0;
  logic [31:0] prev_pc = 32'h0;
  logic [31:0] prev_instr = 32'h0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk         (clk),
    .reset       (reset),
    .redirect    (w_redirect),
    .redirect_pc (w_redirect_pc),
    .imem_en     (w_imem_en),
    .imem_addr   (w_imem_addr),
    .imem_rdata  (w_imem_rdata),
    .out_valid   (w_out_valid),
    .out_ready   (w_ready),
    .out_instr   (w_out_instr),
    .out_pc      (w_out_pc)
  );

  function automatic logic [31:0] mf(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  always @(posedge clk) begin
    if (imem_en)   imem_rdata   <= mf(imem_addr);
    if (w_imem_en) w_imem_rdata <= mf(w_imem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Falling-edge monitor: head stability under stall and in-order scoreboard on every fire.
  task automatic mid;
    logic [31:0] e;
    @(negedge clk);
    if (prev_stall && !prev_flush && out_valid) begin
      chk("hold_pc", out_pc, prev_pc);
      chk("hold_instr", out_instr, prev_instr);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_pc", out_pc, 32'hxxxx_xxxx);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", out_pc, e);
        chk("sb_instr", out_instr, mf(e));
      end
    end
    prev_stall = out_valid & ~out_ready;
    prev_flush = redirect | reset;
    prev_pc    = out_pc;
    prev_instr = out_instr;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
    mid;
    chk("rst_imem_en", {31'b0, imem_en}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    tick;

    // Streaming from reset with decode always ready; wrap instance runs alongside.
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c >= 2) exp_q.push_back(32'(4 * (c - 2)));
      mid;
      chk("s1_imem_en", {31'b0, imem_en}, 32'd1);
      chk("s1_imem_addr", imem_addr, 32'(4 * c));
      chk("s1_out_valid", {31'b0, out_valid}, {31'b0, c >= 2});
      if (c == 0) chk("wrap_addr0", w_imem_addr, 32'hFFFF_FFFC);
      if (c == 1) chk("wrap_addr1", w_imem_addr, 32'h0000_0000);
      if (c == 2) chk("wrap_pc0", w_out_pc, 32'hFFFF_FFFC);
      if (c == 3) chk("wrap_pc1", w_out_pc, 32'h0000_0000);
      if (c >= 2 && c <= 3) chk("wrap_valid", {31'b0, w_out_valid}, 32'd1);
      tick;
    end
    chk("s1_drained", 32'(exp_q.size()), 32'd0);

    reset = 1'b1;
    mid;
    chk("rst2_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst2_imem_en", {31'b0, imem_en}, 32'd0);
    tick;

    // Decode stalled for the first five valid cycles.
    reset = 1'b0; out_ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      mid;
      chk("s2_imem_en", {31'b0, imem_en}, {31'b0, c < 2});
      if (c < 2) chk("s2_imem_addr", imem_addr, 32'(4 * c));
      if (c >= 2) begin
        chk("s2_out_valid", {31'b0, out_valid}, 32'd1);
        chk("s2_out_pc", out_pc, 32'h0);
      end
      tick;
    end
    out_ready = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    for (int c = 7; c < 10; c++) begin
      mid;
      chk("s2_release_valid", {31'b0, out_valid}, 32'd1);
      if (c == 7) chk("s2_resume_addr", imem_addr, 32'h8);
      tick;
    end
    chk("s2_drained", 32'(exp_q.size()), 32'd0);

    // Fill the buffer, then redirect to 0x100 while full.
    out_ready = 1'b0;
    mid;
    chk("fill_imem_en", {31'b0, imem_en}, 32'd0);
    tick;
    redirect = 1'b1; redirect_pc = 32'h100;
    mid;
    chk("full_valid", {31'b0, out_valid}, 32'd1);
    chk("full_head_pc", out_pc, 32'hC);
    chk("redir_imem_en", {31'b0, imem_en}, 32'd0);
    tick;
    redirect = 1'b0; out_ready = 1'b1;
    exp_q.push_back(32'h100); exp_q.push_back(32'h104);
    mid;
    chk("redir_flushed", {31'b0, out_valid}, 32'd0);
    chk("redir_imem_en1", {31'b0, imem_en}, 32'd1);
    chk("redir_addr", imem_addr, 32'h100);
    tick;
    mid;
    chk("redir_valid1", {31'b0, out_valid}, 32'd0);
    chk("redir_addr1", imem_addr, 32'h104);
    tick;
    mid;
    chk("redir_valid2", {31'b0, out_valid}, 32'd1);
    tick;
    mid;
    tick;

    // Back-to-back redirects; the fire in the first redirect cycle still counts.
    redirect = 1'b1; redirect_pc = 32'h200;
    exp_q.push_back(32'h108);
    mid;
    chk("b2b_fire_valid", {31'b0, out_valid}, 32'd1);
    tick;
    redirect_pc = 32'h300;
    mid;
    chk("b2b_valid", {31'b0, out_valid}, 32'd0);
    chk("b2b_imem_en", {31'b0, imem_en}, 32'd0);
    tick;
    redirect = 1'b0;
    mid;
    chk("b2b_valid1", {31'b0, out_valid}, 32'd0);
    chk("b2b_imem_en1", {31'b0, imem_en}, 32'd1);
    chk("b2b_addr", imem_addr, 32'h300);
    tick;
    mid;
    chk("b2b_valid2", {31'b0, out_valid}, 32'd0);
    tick;
    exp_q.push_back(32'h300); exp_q.push_back(32'h304);
    mid;
    chk("b2b_valid3", {31'b0, out_valid}, 32'd1);
    tick;
    mid;
    tick;
    chk("b2b_drained", 32'(exp_q.size()), 32'd0);

    // One-cycle reset while the buffer is full.
    out_ready = 1'b0;
    mid;
    chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    tick;
    reset = 1'b1;
    mid;
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_imem_en", {31'b0, imem_en}, 32'd0);
    tick;
    reset = 1'b0; out_ready = 1'b1;
    mid;
    chk("restart_imem_en", {31'b0, imem_en}, 32'd1);
    chk("restart_addr", imem_addr, 32'h0);
    chk("restart_valid", {31'b0, out_valid}, 32'd0);
    tick;
    mid;
    chk("restart_addr1", imem_addr, 32'h4);
    chk("restart_valid1", {31'b0, out_valid}, 32'd0);
    tick;
    exp_q.push_back(32'h0);
    mid;
    chk("restart_valid2", {31'b0, out_valid}, 32'd1);
    tick;
    out_ready = 1'b0;
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
